// File: rtl/icache_param_pkg.sv
// icache_param_pkg: shared types, default geometry and width helpers for the instruction cache
package icache_param_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {IDLE, FILL} icache_state_t;

    localparam int ICACHE_SETS        = 16;
    localparam int ICACHE_BLOCK_WORDS = 2;
    localparam int ICACHE_BYTE_W      = 2;
    localparam int ICACHE_OFF_W       = $clog2(ICACHE_BLOCK_WORDS);
    localparam int ICACHE_IDX_W       = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W       = 32 - ICACHE_BYTE_W - ICACHE_OFF_W - ICACHE_IDX_W;

    typedef struct packed {
        logic                                valid;
        logic [ICACHE_TAG_W-1:0]             tag;
        word_t [ICACHE_BLOCK_WORDS-1:0]      data;
    } icache_line_t;

    function automatic int icache_tag_w(input int sets, input int words);
        return 32 - ICACHE_BYTE_W - $clog2(words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_param_if.sv
// icache_param_if: fetch-side and memory-side handshake bundle of the instruction cache
interface icache_param_if;
    import icache_param_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_param_data_ram.sv
// icache_data_ram: line data storage, written one word per fill beat, read combinationally
module icache_data_ram
    import icache_param_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int OFF_W = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [OFF_W-1:0] woff,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] ridx,
    input  logic [OFF_W-1:0] roff,
    output word_t            rdata
);

    word_t mem_q [1 << (IDX_W + OFF_W)];

    // store the memory word accepted on this fill beat
    always_ff @(posedge clk) begin
        if (we) mem_q[{widx, woff}] <= wdata;
    end

    assign rdata = mem_q[{ridx, roff}];

endmodule

// File: rtl/icache_param.sv
// icache_param: direct-mapped read-only instruction cache with block fill, invalidate-all and hit/miss counters
module icache_param
    import icache_param_pkg::*;
#(
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 2,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    icache_param_if.slave    bus,
    input  logic             inv,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int OFF_B = $clog2(BLOCK_WORDS);
    localparam int OFF_W = OFF_B > 0 ? OFF_B : 1;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = icache_tag_w(SETS, BLOCK_WORDS);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(BLOCK_WORDS - 1);

    icache_state_t    state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic [IDX_W-1:0] midx_q, midx_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [TAG_W-1:0] tag_d [SETS];
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             hit;
    logic             beat;
    word_t            rdata;
    logic             byte_sel_unused;

    assign req_tag         = bus.imemaddr[31 -: TAG_W];
    assign req_idx         = bus.imemaddr[2 + OFF_B +: IDX_W];
    assign req_off         = OFF_B > 0 ? bus.imemaddr[2 +: OFF_W] : '0;
    assign byte_sel_unused = ^bus.imemaddr[1:0];

    icache_data_ram #(
        .IDX_W (IDX_W),
        .OFF_W (OFF_W)
    ) u_ram (
        .clk   (CLK),
        .we    (beat),
        .widx  (midx_q),
        .woff  (cnt_q),
        .wdata (bus.iload),
        .ridx  (req_idx),
        .roff  (req_off),
        .rdata (rdata)
    );

    // lookup, fill sequencing, invalidate and saturating counters
    always_comb begin
        hit        = state_q == IDLE && bus.imemREN && !inv && valid_q[req_idx] && tag_q[req_idx] == req_tag;
        beat       = state_q == FILL && !bus.iwait && !inv;
        state_d    = state_q;
        cnt_d      = cnt_q;
        mtag_d     = mtag_q;
        midx_d     = midx_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        hit_cnt_d  = (hit && hit_cnt_q != '1) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (inv) begin
            valid_d = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (bus.imemREN && !hit) begin
                mtag_d     = req_tag;
                midx_d     = req_idx;
                cnt_d      = '0;
                miss_cnt_d = miss_cnt_q != '1 ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
                state_d    = FILL;
            end
        end else if (!bus.iwait) begin
            cnt_d = cnt_q + OFF_W'(1);
            if (cnt_q == LAST) begin
                tag_d[midx_q]   = mtag_q;
                valid_d[midx_q] = 1'b1;
                state_d         = IDLE;
            end
        end
        bus.ihit     = hit;
        bus.imemload = hit ? rdata : '0;
        bus.iREN     = state_q == FILL;
        bus.iaddr    = state_q == FILL ? ({mtag_q, midx_q, {(OFF_B + 2){1'b0}}} | (32'(cnt_q) << 2)) : '0;
    end

    // state registers with synchronous reset clearing every valid bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mtag_q     <= '0;
            midx_q     <= '0;
            valid_q    <= '0;
            tag_q      <= '{default: '0};
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mtag_q     <= mtag_d;
            midx_q     <= midx_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: scoreboard bench for the instruction cache against a fixed-latency memory model
module tb_icache_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        inv;
    logic [3:0]  hit_cnt;
    logic [3:0]  miss_cnt;
    int          wcnt = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] rd_q[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_dq[$];

    icache_param_if bus();

    icache_param #(
        .SETS        (16),
        .BLOCK_WORDS (2),
        .CNT_W       (4)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .bus      (bus),
        .inv      (inv),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // memory: each word takes two cycles (busy one cycle, then accepted)
    assign bus.iwait = !(bus.iREN && wcnt == 1);
    assign bus.iload = memf(bus.iaddr);

    always @(posedge clk) begin
        wcnt <= (bus.iREN && bus.iwait) ? wcnt + 1 : 0;
        if (bus.iREN && !bus.iwait) rd_q.push_back(bus.iaddr);
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_q.delete();
    endtask

    task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] d);
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        cyc = 1;
        #1;
        while (!bus.ihit && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        d = bus.imemload;
        @(negedge clk);
        bus.imemREN = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.iREN !== 1'b0) begin bad++; $display("FAIL reset_iREN got=%b exp=0", bus.iREN); end
        total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL reset_ihit got=%b exp=0", bus.ihit); end
        total++; if (bus.iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr got=%h exp=0", bus.iaddr); end
        total++; if (bus.imemload !== 32'h0) begin bad++; $display("FAIL reset_imemload got=%h exp=0", bus.imemload); end
        total++; if (hit_cnt !== 4'd0) begin bad++; $display("FAIL reset_hit_cnt got=%0d exp=0", hit_cnt); end
        total++; if (miss_cnt !== 4'd0) begin bad++; $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        int cyc;
        logic [31:0] d, e, g;
        do_reset();
        exp_rd.push_back(32'h40);
        exp_rd.push_back(32'h44);
        exp_dq.push_back(memf(32'h40));
        fetch(32'h40, cyc, d);
        e = exp_dq.pop_front();
        total++; if (cyc !== 6) begin bad++; $display("FAIL cold_latency got=%0d exp=6", cyc); end
        total++; if (d !== e) begin bad++; $display("FAIL cold_data got=%h exp=%h", d, e); end
        total++; if (miss_cnt !== 4'd1) begin bad++; $display("FAIL cold_miss_cnt got=%0d exp=1", miss_cnt); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            g = rd_q.size() > 0 ? rd_q.pop_front() : 32'hDEAD_BEEF;
            total++; if (g !== e) begin bad++; $display("FAIL cold_rd_addr got=%h exp=%h", g, e); end
        end
        exp_dq.push_back(memf(32'h44));
        fetch(32'h44, cyc, d);
        e = exp_dq.pop_front();
        total++; if (cyc !== 1) begin bad++; $display("FAIL follow_latency got=%0d exp=1", cyc); end
        total++; if (d !== e) begin bad++; $display("FAIL follow_data got=%h exp=%h", d, e); end
        total++; if (hit_cnt !== 4'd2) begin bad++; $display("FAIL follow_hit_cnt got=%0d exp=2", hit_cnt); end
        total++; if (rd_q.size() !== 0) begin bad++; $display("FAIL follow_no_read got=%0d exp=0", rd_q.size()); end
    endtask

    task automatic test_conflict();
        int cyc;
        logic [31:0] d, e, g;
        logic [31:0] seq [3] = '{32'h40, 32'h840, 32'h40};
        do_reset();
        foreach (seq[i]) begin
            exp_rd.push_back(seq[i]);
            exp_rd.push_back(seq[i] + 32'h4);
            exp_dq.push_back(memf(seq[i]));
            fetch(seq[i], cyc, d);
            e = exp_dq.pop_front();
            total++; if (cyc !== 6) begin bad++; $display("FAIL conflict_latency[%0d] got=%0d exp=6", i, cyc); end
            total++; if (d !== e) begin bad++; $display("FAIL conflict_data[%0d] got=%h exp=%h", i, d, e); end
            while (exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                g = rd_q.size() > 0 ? rd_q.pop_front() : 32'hDEAD_BEEF;
                total++; if (g !== e) begin bad++; $display("FAIL conflict_rd_addr got=%h exp=%h", g, e); end
            end
        end
        total++; if (miss_cnt !== 4'd3) begin bad++; $display("FAIL conflict_miss_cnt got=%0d exp=3", miss_cnt); end
    endtask

    task automatic test_midfill_change();
        int cyc;
        logic [31:0] d, e, g;
        do_reset();
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h40;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.iREN !== 1'b1) begin bad++; $display("FAIL midfill_in_fill got=%b exp=1", bus.iREN); end
        exp_rd.push_back(32'h40);
        exp_rd.push_back(32'h44);
        exp_rd.push_back(32'h100);
        exp_rd.push_back(32'h104);
        exp_dq.push_back(memf(32'h100));
        fetch(32'h100, cyc, d);
        e = exp_dq.pop_front();
        total++; if (cyc !== 9) begin bad++; $display("FAIL midfill_latency got=%0d exp=9", cyc); end
        total++; if (d !== e) begin bad++; $display("FAIL midfill_data got=%h exp=%h", d, e); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            g = rd_q.size() > 0 ? rd_q.pop_front() : 32'hDEAD_BEEF;
            total++; if (g !== e) begin bad++; $display("FAIL midfill_rd_addr got=%h exp=%h", g, e); end
        end
        exp_dq.push_back(memf(32'h40));
        fetch(32'h40, cyc, d);
        e = exp_dq.pop_front();
        total++; if (cyc !== 1) begin bad++; $display("FAIL midfill_old_hit got=%0d exp=1", cyc); end
        total++; if (d !== e) begin bad++; $display("FAIL midfill_old_data got=%h exp=%h", d, e); end
        total++; if (miss_cnt !== 4'd2) begin bad++; $display("FAIL midfill_miss_cnt got=%0d exp=2", miss_cnt); end
    endtask

    task automatic test_inv_fill();
        int cyc;
        logic [31:0] d;
        do_reset();
        fetch(32'h100, cyc, d);
        rd_q.delete();
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h40;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.iaddr !== 32'h44) begin bad++; $display("FAIL inv_second_beat got=%h exp=00000044", bus.iaddr); end
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        bus.imemREN = 1'b0;
        #1;
        total++; if (bus.iREN !== 1'b0) begin bad++; $display("FAIL inv_abort_iREN got=%b exp=0", bus.iREN); end
        total++; if (rd_q.size() !== 1) begin bad++; $display("FAIL inv_beats got=%0d exp=1", rd_q.size()); end
        total++; if (miss_cnt !== 4'd2) begin bad++; $display("FAIL inv_miss_cnt got=%0d exp=2", miss_cnt); end
        fetch(32'h40, cyc, d);
        total++; if (cyc !== 6) begin bad++; $display("FAIL inv_refetch_latency got=%0d exp=6", cyc); end
        total++; if (d !== memf(32'h40)) begin bad++; $display("FAIL inv_refetch_data got=%h exp=%h", d, memf(32'h40)); end
        total++; if (miss_cnt !== 4'd3) begin bad++; $display("FAIL inv_refetch_miss_cnt got=%0d exp=3", miss_cnt); end
        fetch(32'h100, cyc, d);
        total++; if (cyc !== 6) begin bad++; $display("FAIL inv_other_line got=%0d exp=6", cyc); end
        total++; if (miss_cnt !== 4'd4) begin bad++; $display("FAIL inv_other_miss_cnt got=%0d exp=4", miss_cnt); end
    endtask

    task automatic test_reset_midfill();
        int cyc;
        logic [31:0] d;
        do_reset();
        fetch(32'h40, cyc, d);
        fetch(32'h40, cyc, d);
        total++; if (hit_cnt !== 4'd2) begin bad++; $display("FAIL rstfill_pre_hits got=%0d exp=2", hit_cnt); end
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h100;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.imemREN = 1'b0;
        #1;
        total++; if (bus.iREN !== 1'b0) begin bad++; $display("FAIL rstfill_iREN got=%b exp=0", bus.iREN); end
        total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL rstfill_ihit got=%b exp=0", bus.ihit); end
        total++; if (hit_cnt !== 4'd0) begin bad++; $display("FAIL rstfill_hit_cnt got=%0d exp=0", hit_cnt); end
        total++; if (miss_cnt !== 4'd0) begin bad++; $display("FAIL rstfill_miss_cnt got=%0d exp=0", miss_cnt); end
        fetch(32'h40, cyc, d);
        total++; if (cyc !== 6) begin bad++; $display("FAIL rstfill_old_misses got=%0d exp=6", cyc); end
        rd_q.delete();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] d, a;
        do_reset();
        fetch(32'h40, cyc, d);
        bus.imemREN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = i[0] ? 32'h44 : 32'h40;
            bus.imemaddr = a;
            #1;
            total++; if (bus.ihit !== 1'b1 || bus.imemload !== memf(a)) begin bad++; $display("FAIL b2b_hit[%0d] got=%b/%h exp=1/%h", i, bus.ihit, bus.imemload, memf(a)); end
            @(negedge clk);
        end
        bus.imemREN = 1'b0;
        #1;
        total++; if (bus.imemload !== 32'h0) begin bad++; $display("FAIL b2b_idle_load got=%h exp=0", bus.imemload); end
        total++; if (hit_cnt !== 4'd5) begin bad++; $display("FAIL b2b_hit_cnt got=%0d exp=5", hit_cnt); end
    endtask

    task automatic test_saturation();
        int cyc;
        logic [31:0] d;
        do_reset();
        fetch(32'h40, cyc, d);
        for (int i = 2; i <= 20; i++) begin
            fetch(i[0] ? 32'h44 : 32'h40, cyc, d);
            total++; if (cyc !== 1) begin bad++; $display("FAIL sat_hit[%0d] got=%0d exp=1", i, cyc); end
            if (i == 14) begin
                total++; if (hit_cnt !== 4'd14) begin bad++; $display("FAIL sat_pre got=%0d exp=14", hit_cnt); end
            end
        end
        total++; if (hit_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", hit_cnt); end
        total++; if (miss_cnt !== 4'd1) begin bad++; $display("FAIL sat_miss_cnt got=%0d exp=1", miss_cnt); end
    endtask

    initial begin
        rst          = 1'b1;
        inv          = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_conflict();
        test_midfill_change();
        test_inv_fill();
        test_reset_midfill();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
